uart_rx_os: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_os.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver.
// FSM state encoding, minimum data width and tick-counter sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int MIN_DATA = 5;

  function automatic int cnt_w(input int osr);
    return $clog2(osr);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both stages reset to 1, the idle level of the line.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: mid-bit sampling, programmable format.
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_MAX = 9,
  parameter int OSR      = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tick_i,
  input  logic                en_i,
  input  logic                rx_i,
  input  logic [3:0]          data_size_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  input  logic [1:0]          stop_size_i,
  output logic [DATA_MAX-1:0] data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                parity_err_o,
  output logic                frame_err_o,
  output logic                overrun_o,
`ifdef UART_RX_BREAK_DET_EN
  output logic                break_o,
`endif
  output logic [2:0]          state_o
);

  localparam int CW = cnt_w(OSR);
  localparam logic [CW-1:0] HALF = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OSR - 1);
  localparam logic [3:0] DMAX = 4'(DATA_MAX);
  localparam logic [3:0] DMIN = 4'(MIN_DATA);

  logic                rxs;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [3:0]          bit_q, size_q, size_d;
  logic                par_en_q, odd_q;
  logic                stop2_q, stop_n_q;
  logic [DATA_MAX-1:0] shreg_q;
  logic                par_q, ferr_q;
  logic                start, sample;
  logic                last_data, last_stop;
  logic                push_raw, push, is_brk;
  logic                push_perr, push_ferr;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d      (rx_i),
    .q      (rxs)
  );

  always_comb begin
    size_d = data_size_i;
    if (data_size_i < DMIN) size_d = DMIN;
    else if (data_size_i > DMAX) size_d = DMAX;
  end

  assign start = tick_i & en_i & ~rxs
               & (state_q == IDLE);
  // START samples half a bit in; every later sample is a full bit on
  assign sample = tick_i & (state_q != IDLE)
                & (cnt_q == ((state_q == START) ? HALF : FULL));
  assign last_data = bit_q == size_q - 4'd1;
  assign last_stop = ~stop2_q | stop_n_q;

  always_comb begin
    state_d  = state_q;
    push_raw = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = START;
      START:  if (sample) state_d = rxs ? IDLE : DATA;
      DATA: begin
        if (sample && last_data)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (sample) state_d = STOP;
      STOP: begin
        if (sample && last_stop) begin
          state_d  = IDLE;
          push_raw = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      size_q   <= '0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      stop2_q  <= 1'b0;
      stop_n_q <= 1'b0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (start) begin
      size_q   <= size_d;
      par_en_q <= parity_en_i;
      odd_q    <= parity_odd_i;
      stop2_q  <= stop_size_i[1];
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_n_q <= 1'b0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (tick_i && state_q != IDLE) begin
      cnt_q <= sample ? '0 : cnt_q + 1'b1;
      if (sample && state_q == DATA) begin
        for (int i = 0; i < DATA_MAX; i++)
          if (bit_q == 4'(i)) shreg_q[i] <= rxs;
        bit_q <= bit_q + 4'd1;
      end
      if (sample && (state_q == DATA || state_q == PARITY))
        par_q <= par_q ^ rxs;
      if (sample && state_q == STOP) begin
        stop_n_q <= 1'b1;
        ferr_q   <= ferr_q | ~rxs;
      end
    end
  end

  assign push_perr = par_en_q & (par_q ^ odd_q);
  assign push_ferr = ferr_q | ~rxs;

`ifdef UART_RX_BREAK_DET_EN
  logic zero_q;

  // Break: every sampled bit after the start bit was low
  assign is_brk = push_raw & zero_q & ~rxs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q  <= 1'b0;
      break_o <= 1'b0;
    end else begin
      if (start)
        zero_q <= 1'b1;
      else if (sample && state_q != START)
        zero_q <= zero_q & ~rxs;
      if (is_brk)
        break_o <= 1'b1;
      else if (tick_i && rxs)
        break_o <= 1'b0;
    end
  end
`else
  assign is_brk = 1'b0;
`endif

  assign push = push_raw & ~is_brk;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o      <= 1'b0;
      data_o       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (push) begin
        if (!valid_o || ready_i) begin
          valid_o      <= 1'b1;
          data_o       <= shreg_q;
          parity_err_o <= push_perr;
          frame_err_o  <= push_ferr;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_os;

  localparam int OSR  = 16;
  localparam int DMAX = 9;
  localparam int BITC = OSR * 2;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tick_i = 1'b0;
  logic       en_i = 1'b1;
  logic       rx_i = 1'b1;
  logic [3:0] data_size_i = 4'd8;
  logic       parity_en_i = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic [1:0] stop_size_i = 2'd1;
  logic       ready_i = 1'b1;
  logic [8:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic [2:0] state_o;
`ifdef UART_RX_BREAK_DET_EN
  logic       break_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_ovr = 0;
  int n_vrise = 0;
  int n_vcyc = 0;
  logic v_prev = 1'b0;

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
  } cap_t;
  cap_t cap_q[$];

  uart_rx_os #(.DATA_MAX(DMAX), .OSR(OSR)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .tick_i       (tick_i),
    .en_i         (en_i),
    .rx_i         (rx_i),
    .data_size_i  (data_size_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop_size_i  (stop_size_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
`ifdef UART_RX_BREAK_DET_EN
    .break_o      (break_o),
`endif
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    tick_i = ~tick_i;
  end

  always @(negedge clk) begin
    if (overrun_o) n_ovr++;
    if (valid_o && !v_prev) n_vrise++;
    if (valid_o) n_vcyc++;
    v_prev = valid_o;
    if (valid_o && ready_i)
      cap_q.push_back({data_o, parity_err_o, frame_err_o});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cap(output bit ok);
    int w = 0;
    while (cap_q.size() == 0 && w < 8 * BITC) begin
      step(1);
      w++;
    end
    ok = cap_q.size() != 0;
  endtask

  task automatic send_frame(input logic [8:0] d, input int n,
                            input bit pe, input bit pb,
                            input int ns, input bit [1:0] sb,
                            input bit scr);
    rx_i = 1'b0;
    step(BITC);
    if (scr) begin
      data_size_i  = 4'($urandom);
      parity_en_i  = 1'($urandom);
      parity_odd_i = 1'($urandom);
      stop_size_i  = 2'($urandom);
      en_i         = 1'($urandom);
    end
    for (int i = 0; i < n; i++) begin
      rx_i = d[i];
      step(BITC);
    end
    if (pe) begin
      rx_i = pb;
      step(BITC);
    end
    for (int i = 0; i < ns; i++) begin
      rx_i = sb[i];
      step(BITC);
    end
    rx_i = 1'b1;
    step(2 * BITC);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({valid_o, data_o, parity_err_o, frame_err_o,
         overrun_o, state_o} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h p=%b f=%b o=%b s=%0d want all 0",
               valid_o, data_o, parity_err_o, frame_err_o,
               overrun_o, state_o);
    end
`ifdef UART_RX_BREAK_DET_EN
    n_cmp++;
    if (break_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_break: got %b want 0", break_o);
    end
`endif
    step(1);
    rst_ni = 1'b1;
    step(2 * BITC);
  endtask

  task automatic test_8n1();
    int v0;
    bit ok;
    cap_t c;
    data_size_i = 4'd8;
    parity_en_i = 1'b0;
    stop_size_i = 2'd1;
    ready_i = 1'b1;
    v0 = n_vrise;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    wait_cap(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL 8n1_timeout: no word, want 0a5");
    end else begin
      c = cap_q.pop_front();
      n_cmp++;
      if (c.d !== 9'h0A5) begin
        n_err++;
        $display("FAIL 8n1_data: got %h want 0a5", c.d);
      end
      n_cmp++;
      if ({c.p, c.f} !== 2'b00) begin
        n_err++;
        $display("FAIL 8n1_flags: got p=%b f=%b want 0 0", c.p, c.f);
      end
    end
    n_cmp++;
    if (n_vrise - v0 != 1) begin
      n_err++;
      $display("FAIL 8n1_pulses: got %0d want 1", n_vrise - v0);
    end
  endtask

  task automatic test_parity();
    bit ok;
    cap_t c;
    data_size_i  = 4'd7;
    parity_en_i  = 1'b1;
    parity_odd_i = 1'b0;
    stop_size_i  = 2'd1;
    send_frame(9'h041, 7, 1'b1, 1'b1, 1, 2'b11, 1'b0);
    wait_cap(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL par_timeout: no word, want 041");
    end else begin
      c = cap_q.pop_front();
      n_cmp++;
      if (c.d !== 9'h041 || c.p !== 1'b1 || c.f !== 1'b0) begin
        n_err++;
        $display("FAIL par_word: got d=%h p=%b f=%b want 041 1 0",
                 c.d, c.p, c.f);
      end
    end
  endtask

  task automatic test_frame_err();
    bit ok;
    cap_t c;
    data_size_i  = 4'd9;
    parity_en_i  = 1'b1;
    parity_odd_i = 1'b1;
    stop_size_i  = 2'd2;
    send_frame(9'h1FF, 9, 1'b1, 1'b0, 2, 2'b01, 1'b0);
    wait_cap(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL ferr_timeout: no word, want 1ff");
    end else begin
      c = cap_q.pop_front();
      n_cmp++;
      if (c.d !== 9'h1FF || c.p !== 1'b0 || c.f !== 1'b1) begin
        n_err++;
        $display("FAIL ferr_word: got d=%h p=%b f=%b want 1ff 0 1",
                 c.d, c.p, c.f);
      end
    end
  endtask

  task automatic test_false_start();
    int v0;
    data_size_i = 4'd8;
    parity_en_i = 1'b0;
    stop_size_i = 2'd1;
    v0 = n_vcyc;
    rx_i = 1'b0;
    step(6);
    rx_i = 1'b1;
    step(4);
    n_cmp++;
    if (state_o !== 3'd1) begin
      n_err++;
      $display("FAIL fs_start: got state %0d want 1", state_o);
    end
    step(3 * BITC);
    n_cmp++;
    if (state_o !== 3'd0 || n_vcyc != v0 || cap_q.size() != 0) begin
      n_err++;
      $display("FAIL fs_idle: got state %0d valid_cycles %0d want 0 0",
               state_o, n_vcyc - v0);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    bit ok;
    cap_t c;
    ready_i = 1'b0;
    o0 = n_ovr;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 9'h011) begin
      n_err++;
      $display("FAIL b2b_hold: got v=%b d=%h want 1 011", valid_o, data_o);
    end
    n_cmp++;
    if (n_ovr - o0 != 1) begin
      n_err++;
      $display("FAIL b2b_overrun: got %0d pulses want 1", n_ovr - o0);
    end
    ready_i = 1'b1;
    wait_cap(ok);
    step(2);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL b2b_timeout: no word, want 011");
    end else begin
      c = cap_q.pop_front();
      n_cmp++;
      if (c.d !== 9'h011 || valid_o !== 1'b0 || cap_q.size() != 0) begin
        n_err++;
        $display("FAIL b2b_drain: got d=%h v=%b extra=%0d want 011 0 0",
                 c.d, valid_o, cap_q.size());
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    cap_t c;
    data_size_i = 4'd8;
    parity_en_i = 1'b0;
    stop_size_i = 2'd1;
    rx_i = 1'b0;
    step(BITC);
    rx_i = 1'b1;
    step(BITC);
    rx_i = 1'b0;
    step(BITC / 2);
    n_cmp++;
    if (state_o !== 3'd2) begin
      n_err++;
      $display("FAIL mr_data: got state %0d want 2", state_o);
    end
    rst_ni = 1'b0;
    rx_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({valid_o, data_o, parity_err_o, frame_err_o,
         overrun_o, state_o} !== 16'h0) begin
      n_err++;
      $display("FAIL mr_reset: got v=%b d=%h p=%b f=%b o=%b s=%0d want all 0",
               valid_o, data_o, parity_err_o, frame_err_o,
               overrun_o, state_o);
    end
    step(2);
    rst_ni = 1'b1;
    step(2 * BITC);
    n_cmp++;
    if (cap_q.size() != 0) begin
      n_err++;
      $display("FAIL mr_partial: got %0d words want 0", cap_q.size());
    end
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    wait_cap(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL mr_timeout: no word, want 03c");
    end else begin
      c = cap_q.pop_front();
      n_cmp++;
      if (c.d !== 9'h03C || c.p !== 1'b0 || c.f !== 1'b0) begin
        n_err++;
        $display("FAIL mr_word: got d=%h p=%b f=%b want 03c 0 0",
                 c.d, c.p, c.f);
      end
    end
  endtask

  task automatic test_break();
    data_size_i = 4'd8;
    parity_en_i = 1'b0;
    stop_size_i = 2'd1;
`ifdef UART_RX_BREAK_DET_EN
    begin
      int v0;
      v0 = n_vcyc;
      rx_i = 1'b0;
      step(12 * BITC);
      n_cmp++;
      if (break_o !== 1'b1 || n_vcyc != v0) begin
        n_err++;
        $display("FAIL brk_set: got break=%b valid_cycles=%0d want 1 0",
                 break_o, n_vcyc - v0);
      end
      rx_i = 1'b1;
      step(8);
      n_cmp++;
      if (break_o !== 1'b0) begin
        n_err++;
        $display("FAIL brk_clear: got %b want 0", break_o);
      end
      step(12 * BITC);
      cap_q.delete();
    end
`else
    begin
      bit ok;
      cap_t c;
      send_frame(9'h000, 8, 1'b0, 1'b0, 1, 2'b00, 1'b0);
      wait_cap(ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL brk_timeout: no word, want 000 with frame error");
      end else begin
        c = cap_q.pop_front();
        n_cmp++;
        if (c.d !== 9'h000 || c.f !== 1'b1) begin
          n_err++;
          $display("FAIL brk_word: got d=%h f=%b want 000 1", c.d, c.f);
        end
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      logic [8:0] d, ed;
      int sz, ss, n, ns;
      bit pe, od, wr, pb, ep, ef, ok;
      bit [1:0] sb;
      cap_t c;
      sz = $urandom_range(0, 15);
      ss = $urandom_range(0, 3);
      pe = 1'($urandom_range(0, 1));
      od = 1'($urandom_range(0, 1));
      d  = 9'($urandom);
      n  = sz < 5 ? 5 : (sz > DMAX ? DMAX : sz);
      ns = ss == 0 ? 1 : (ss > 1 ? 2 : 1);
      sb = 2'b11;
      if ($urandom_range(0, 3) == 0) begin
        sb[$urandom_range(0, ns - 1)] = 1'b0;
        d[0] = 1'b1;
      end
      ed = '0;
      for (int i = 0; i < n; i++) ed[i] = d[i];
      wr = $urandom_range(0, 3) == 0;
      pb = (^ed) ^ od ^ wr;
      ep = pe && ((^ed) ^ pb ^ od);
      ef = !sb[0] || (ns == 2 && !sb[1]);
      en_i = 1'b1;
      data_size_i  = 4'(sz);
      stop_size_i  = 2'(ss);
      parity_en_i  = pe;
      parity_odd_i = od;
      send_frame(d, n, pe, pb, ns, sb, 1'b1);
      wait_cap(ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL rand_timeout %0d: no word, want %h", k, ed);
      end else begin
        c = cap_q.pop_front();
        n_cmp++;
        if (c.d !== ed) begin
          n_err++;
          $display("FAIL rand_data %0d: got %h want %h (size %0d)",
                   k, c.d, ed, sz);
        end
        n_cmp++;
        if ({c.p, c.f} !== {ep, ef}) begin
          n_err++;
          $display("FAIL rand_flags %0d: got p=%b f=%b want %b %b",
                   k, c.p, c.f, ep, ef);
        end
      end
    end
    en_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_false_start();
    test_back_to_back();
    test_mid_reset();
    test_break();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
